// File: rtl/video_pkg.sv
// Shared definitions for the video fetch path: bandwidth codes, byte-select
// codes and the request state machine encoding.
package video_pkg;

    localparam logic [1:0] BW2 = 2'b00;
    localparam logic [1:0] BW4 = 2'b01;
    localparam logic [1:0] BW8 = 2'b11;

    localparam logic [2:0] BU1 = 3'b001;
    localparam logic [2:0] BU2 = 3'b010;
    localparam logic [2:0] BU4 = 3'b100;

    localparam logic [1:0] BSL_NAT = 2'b10;
    localparam logic [1:0] BSL_LO  = 2'b00;
    localparam logic [1:0] BSL_HI  = 2'b11;

    typedef enum logic {IDLE, REQ} req_state_t;

    // Last slot index of a bandwidth window; the unused code 2'b10 behaves as BW8.
    function automatic logic [2:0] bw_last_slot(input logic [1:0] win);
        case (win)
            BW2:     return 3'd1;
            BW4:     return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Request slots per window; a malformed one-hot code requests nothing.
    function automatic logic [2:0] bw_need(input logic [2:0] bu);
        case (bu)
            BU1:     return 3'd1;
            BU2:     return 3'd2;
            BU4:     return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/video_fetch_buf_if.sv
// DRAM read port of the video fetch stage: request/accept plus returned data.
interface video_fetch_buf_if #(
    parameter int AW = 21
);
    logic          dram_req;
    logic [AW-1:0] dram_addr;
    logic          dram_next;
    logic          dram_strb;
    logic [15:0]   dram_rdata;

    modport master (
        output dram_req, dram_addr,
        input  dram_next, dram_strb, dram_rdata
    );

    modport slave (
        input  dram_req, dram_addr,
        output dram_next, dram_strb, dram_rdata
    );
endinterface

// File: rtl/video_fetch_fifo.sv
// Synchronous word FIFO with flush; a word written in a cycle becomes visible
// to the read side on the following cycle.
module video_fetch_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/video_fetch_buf.sv
// Video DRAM fetch stage: paces read requests, buffers returned words and
// steers them into the renderer fetch register. VFETCH_STATS_EN adds counters.
module video_fetch_buf
    import video_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int AW    = 21,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c3,
    input  logic                     line_start_s,
    input  logic                     video_go,
    input  logic [4:0]               video_bw,
    input  logic [AW-1:0]            video_addr,
    input  logic                     fetch_stb,
    input  logic [3:0]               fetch_sel,
    input  logic [1:0]               fetch_bsl,
    video_fetch_buf_if.master        dram,
    output logic [31:0]              fetch_data,
    output logic                     fifo_empty,
    output logic                     underrun
`ifdef VFETCH_STATS_EN
    ,
    output logic [7:0]               underrun_cnt,
    output logic [CW-1:0]            fifo_hwm
`endif
);

    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    req_state_t    state;
    logic [2:0]    slot;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fifo_word;
    logic          fifo_full;
    logic          eligible;
    logic          accept;
    logic          ret;
    logic          push;
    logic          pop;
    logic          underrun_ev;
    logic [31:0]   steered;
    logic [31:0]   lane_mask;

    // Reserve FIFO space for every word still in flight, so returns never overflow.
    assign eligible = video_go && !fifo_full
                   && (slot < bw_need(video_bw[2:0]))
                   && (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W);

    assign accept      = (state == REQ) && dram.dram_next && !line_start_s;
    assign ret         = dram.dram_strb && (outstanding != '0);
    assign push        = dram.dram_strb && (discard == '0) && !line_start_s;
    assign pop         = fetch_stb && !fifo_empty && !line_start_s;
    assign underrun_ev = fetch_stb && fifo_empty;

    video_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (line_start_s),
        .push  (push),
        .pop   (pop),
        .wdata (dram.dram_rdata),
        .rdata (fifo_word),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (line_start_s || !video_go) begin
            slot <= '0;
        end else if (c3) begin
            slot <= (slot == bw_last_slot(video_bw[4:3])) ? 3'd0 : slot + 1'b1;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            dram.dram_req  <= 1'b0;
            dram.dram_addr <= '0;
        end else if (line_start_s) begin
            state         <= IDLE;
            dram.dram_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (c3 && eligible) begin
                        state          <= REQ;
                        dram.dram_req  <= 1'b1;
                        dram.dram_addr <= video_addr;
                    end
                end
                REQ: begin
                    if (dram.dram_next) begin
                        state         <= IDLE;
                        dram.dram_req <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    dram.dram_req <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding counts every word in flight; a flush marks the current ones
    // as stale so their returns are dropped in arrival order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case ({accept, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            if (line_start_s) begin
                discard <= outstanding - CW'(ret);
            end else if (ret && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

    // Even lanes take their byte from fetch_bsl[0], odd lanes from fetch_bsl[1].
    assign steered = {fetch_bsl[1] ? fifo_word[15:8] : fifo_word[7:0],
                      fetch_bsl[0] ? fifo_word[15:8] : fifo_word[7:0],
                      fetch_bsl[1] ? fifo_word[15:8] : fifo_word[7:0],
                      fetch_bsl[0] ? fifo_word[15:8] : fifo_word[7:0]};
    assign lane_mask = {{8{fetch_sel[3]}}, {8{fetch_sel[2]}},
                        {8{fetch_sel[1]}}, {8{fetch_sel[0]}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_data <= '0;
            underrun   <= 1'b0;
        end else begin
            if (pop) begin
                fetch_data <= (fetch_data & ~lane_mask) | (steered & lane_mask);
            end
            if (line_start_s) begin
                underrun <= 1'b0;
            end else if (underrun_ev) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef VFETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
            fifo_hwm     <= '0;
        end else begin
            if (underrun_ev && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
            if (fifo_count > fifo_hwm) begin
                fifo_hwm <= fifo_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_fetch_buf.sv
// Directed bench for video_fetch_buf: pacing, lane steering, backpressure,
// underrun and flush/discard, plus the statistics ports when enabled.
module tb_video_fetch_buf;
    import video_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 21;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          c3           = 1'b0;
    logic          line_start_s = 1'b0;
    logic          video_go     = 1'b0;
    logic [4:0]    video_bw     = '0;
    logic [AW-1:0] video_addr   = '0;
    logic          fetch_stb    = 1'b0;
    logic [3:0]    fetch_sel    = '0;
    logic [1:0]    fetch_bsl    = '0;
    logic [31:0]   fetch_data;
    logic          fifo_empty;
    logic          underrun;
`ifdef VFETCH_STATS_EN
    logic [7:0]    underrun_cnt;
    logic [CW-1:0] fifo_hwm;
`endif

    logic        auto_next = 1'b0;
    logic        auto_ret  = 1'b0;
    logic        auto_pop  = 1'b0;
    logic        man_next  = 1'b0;
    logic        tb_strb   = 1'b0;
    logic [15:0] tb_rdata  = '0;
    logic        ret_pend  = 1'b0;
    logic [15:0] ret_data  = '0;
    logic        overflow_seen = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    int          acc_cnt = 0;

    video_fetch_buf_if #(.AW(AW)) bus ();

    assign bus.dram_next  = auto_next ? bus.dram_req : man_next;
    assign bus.dram_strb  = tb_strb;
    assign bus.dram_rdata = tb_rdata;

    video_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .c3           (c3),
        .line_start_s (line_start_s),
        .video_go     (video_go),
        .video_bw     (video_bw),
        .video_addr   (video_addr),
        .fetch_stb    (fetch_stb),
        .fetch_sel    (fetch_sel),
        .fetch_bsl    (fetch_bsl),
        .dram         (bus),
        .fetch_data   (fetch_data),
        .fifo_empty   (fifo_empty),
        .underrun     (underrun)
`ifdef VFETCH_STATS_EN
        ,
        .underrun_cnt (underrun_cnt),
        .fifo_hwm     (fifo_hwm)
`endif
    );

    always #5 clk = ~clk;

    // Accepted requests, and any write attempt into a full FIFO.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.dram_req && bus.dram_next && !line_start_s) acc_cnt <= acc_cnt + 1;
            if (dut.u_fifo.push && dut.u_fifo.full) overflow_seen <= 1'b1;
        end
    end

    // DRAM model returns each accepted address one cycle later; optional drain.
    always @(negedge clk) begin
        if (auto_ret) begin
            tb_strb  = ret_pend;
            tb_rdata = ret_data;
            ret_pend = bus.dram_req && bus.dram_next;
            ret_data = bus.dram_addr[15:0];
        end
        if (auto_pop) fetch_stb = !fifo_empty;
    end

    task automatic do_reset();
        @(negedge clk);
        auto_next = 0; auto_ret = 0; auto_pop = 0; man_next = 0;
        tb_strb = 0; ret_pend = 0; c3 = 0; line_start_s = 0; video_go = 0;
        fetch_stb = 0; fetch_sel = '0; fetch_bsl = '0; video_addr = '0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        acc_cnt = 0;
    endtask

    task automatic issue_c3();
        @(negedge clk); c3 = 1;
        @(negedge clk); c3 = 0;
        @(negedge clk);
    endtask

    task automatic return_word(input logic [15:0] w);
        @(negedge clk); tb_strb = 1; tb_rdata = w;
        @(negedge clk); tb_strb = 0;
    endtask

    task automatic fetch(input logic [3:0] sel, input logic [1:0] bsl);
        @(negedge clk); fetch_stb = 1; fetch_sel = sel; fetch_bsl = bsl;
        @(negedge clk); fetch_stb = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.dram_req !== 1'b0) begin errors++; $display("FAIL reset dram_req: got %b want 0", bus.dram_req); end
        checks++; if (bus.dram_addr !== '0) begin errors++; $display("FAIL reset dram_addr: got %h want 0", bus.dram_addr); end
        checks++; if (fetch_data !== 32'h0) begin errors++; $display("FAIL reset fetch_data: got %h want 0", fetch_data); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset fifo_empty: got %b want 1", fifo_empty); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset underrun: got %b want 0", underrun); end
        rst = 0;
    endtask

    task automatic test_pacing(input logic [4:0] bw, input int win, input int need, input int total);
        logic exp_req;
        do_reset();
        video_bw = bw; video_go = 1; auto_next = 1; auto_ret = 1; auto_pop = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            video_addr = AW'(32'h1000 + 16 * k);
            c3 = 1;
            @(posedge clk); #1;
            exp_req = ((k % win) < need);
            checks++;
            if (bus.dram_req !== exp_req) begin
                errors++; $display("FAIL pacing bw=%b c3#%0d dram_req: got %b want %b", bw, k, bus.dram_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (bus.dram_addr !== video_addr) begin
                    errors++; $display("FAIL pacing bw=%b c3#%0d dram_addr: got %h want %h", bw, k, bus.dram_addr, video_addr);
                end
            end
            @(negedge clk); c3 = 0;
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        checks++; if (acc_cnt !== total) begin errors++; $display("FAIL pacing bw=%b request count: got %0d want %0d", bw, acc_cnt, total); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL pacing bw=%b drained: fifo_empty %b want 1", bw, fifo_empty); end
        auto_pop = 0; auto_ret = 0; fetch_stb = 0; video_go = 0;
    endtask

    task automatic test_lane_steering();
        do_reset();
        video_bw = 5'b11100; video_go = 1; auto_next = 1;
        repeat (4) issue_c3();
        video_go = 0;
        checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL lanes request count: got %0d want 4", acc_cnt); end
        return_word(16'hA55A); return_word(16'hA55A); return_word(16'hA55A); return_word(16'h1234);
        fetch(4'b0001, BSL_LO);
        checks++; if (fetch_data !== 32'h0000005A) begin errors++; $display("FAIL lanes sel0001 lo: got %h want 0000005a", fetch_data); end
        fetch(4'b0011, BSL_NAT);
        checks++; if (fetch_data !== 32'h0000A55A) begin errors++; $display("FAIL lanes sel0011 nat: got %h want 0000a55a", fetch_data); end
        fetch(4'b1100, BSL_HI);
        checks++; if (fetch_data !== 32'hA5A5A55A) begin errors++; $display("FAIL lanes sel1100 hi: got %h want a5a5a55a", fetch_data); end
        fetch(4'b0100, BSL_NAT);
        checks++; if (fetch_data !== 32'hA534A55A) begin errors++; $display("FAIL lanes sel0100 nat: got %h want a534a55a", fetch_data); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL lanes fifo_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_backpressure();
        do_reset();
        video_bw = 5'b11100; video_go = 1; auto_next = 1;
        repeat (24) issue_c3();
        checks++; if (acc_cnt !== DEPTH) begin errors++; $display("FAIL backpressure in-flight limit: got %0d want %0d", acc_cnt, DEPTH); end
        for (int i = 0; i < DEPTH; i++) return_word(16'h0100 + 16'(i));
        repeat (16) issue_c3();
        checks++; if (acc_cnt !== DEPTH) begin errors++; $display("FAIL backpressure full fifo: got %0d want %0d", acc_cnt, DEPTH); end
        fetch(4'b1111, BSL_NAT);
        checks++; if (fetch_data !== 32'h01000100) begin errors++; $display("FAIL backpressure first word: got %h want 01000100", fetch_data); end
        repeat (16) issue_c3();
        checks++; if (acc_cnt !== DEPTH + 1) begin errors++; $display("FAIL backpressure after pop: got %0d want %0d", acc_cnt, DEPTH + 1); end
        video_go = 0;
    endtask

    task automatic test_underrun();
        do_reset();
        video_bw = 5'b11001; video_go = 1; auto_next = 1;
        issue_c3();
        video_go = 0;
        return_word(16'hBEEF);
        fetch(4'b1111, BSL_NAT);
        checks++; if (fetch_data !== 32'hBEEFBEEF) begin errors++; $display("FAIL underrun setup word: got %h want beefbeef", fetch_data); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun before: got %b want 0", underrun); end
        fetch(4'b1111, BSL_LO);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun flag: got %b want 1", underrun); end
        checks++; if (fetch_data !== 32'hBEEFBEEF) begin errors++; $display("FAIL underrun hold: got %h want beefbeef", fetch_data); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL underrun empty: got %b want 1", fifo_empty); end
`ifdef VFETCH_STATS_EN
        checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL underrun_cnt one: got %0d want 1", underrun_cnt); end
        checks++; if (fifo_hwm !== CW'(1)) begin errors++; $display("FAIL fifo_hwm: got %0d want 1", fifo_hwm); end
`endif
        @(negedge clk); line_start_s = 1;
        @(negedge clk); line_start_s = 0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun clear: got %b want 0", underrun); end
`ifdef VFETCH_STATS_EN
        checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL underrun_cnt kept on line start: got %0d want 1", underrun_cnt); end
        @(negedge clk); fetch_stb = 1; fetch_sel = 4'b0000;
        repeat (300) @(negedge clk);
        fetch_stb = 0;
        checks++; if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL underrun_cnt saturate: got %0d want 255", underrun_cnt); end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        video_bw = 5'b11100; video_go = 1; auto_next = 1;
        repeat (2) issue_c3();
        checks++; if (acc_cnt !== 2) begin errors++; $display("FAIL flush outstanding setup: got %0d want 2", acc_cnt); end
        @(negedge clk); line_start_s = 1;
        @(negedge clk); line_start_s = 0;
        issue_c3();
        checks++; if (acc_cnt !== 3) begin errors++; $display("FAIL flush new request: got %0d want 3", acc_cnt); end
        return_word(16'h1111);
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush discard 1: fifo_empty %b want 1", fifo_empty); end
        return_word(16'h2222);
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush discard 2: fifo_empty %b want 1", fifo_empty); end
        return_word(16'h3333);
        checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL flush third accepted: fifo_empty %b want 0", fifo_empty); end
        fetch(4'b1111, BSL_NAT);
        checks++; if (fetch_data !== 32'h33333333) begin errors++; $display("FAIL flush third word: got %h want 33333333", fetch_data); end
        auto_next = 0; man_next = 0;
        @(negedge clk); video_addr = 21'h155AA; c3 = 1;
        @(negedge clk); c3 = 0;
        checks++; if (bus.dram_req !== 1'b1) begin errors++; $display("FAIL async setup dram_req: got %b want 1", bus.dram_req); end
        checks++; if (bus.dram_addr !== 21'h155AA) begin errors++; $display("FAIL async setup dram_addr: got %h want 155aa", bus.dram_addr); end
        #2 rst = 1;
        #1;
        checks++; if (bus.dram_req !== 1'b0) begin errors++; $display("FAIL async reset dram_req: got %b want 0", bus.dram_req); end
        checks++; if (bus.dram_addr !== '0) begin errors++; $display("FAIL async reset dram_addr: got %h want 0", bus.dram_addr); end
        @(negedge clk); rst = 0; video_go = 0;
    endtask

    initial begin
        test_reset();
        test_pacing(5'b11001, 8, 1, 2);
        test_pacing(5'b11100, 8, 4, 8);
        test_pacing(5'b01010, 4, 2, 8);
        test_pacing(5'b00001, 2, 1, 8);
        test_lane_steering();
        test_backpressure();
        test_underrun();
        test_flush();
        checks++; if (overflow_seen !== 1'b0) begin errors++; $display("FAIL fifo overflow: push into full fifo seen %b want 0", overflow_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
